// File: rtl/dmc_ui_arb_pkg.sv
// Shared definitions for the DDR UI-port arbiter: app command encodings and FSM states.
package dmc_ui_arb_pkg;

    localparam logic [2:0] DMC_CMD_WRITE = 3'b000;
    localparam logic [2:0] DMC_CMD_READ  = 3'b001;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CMD   = 2'd1,
        WDATA = 2'd2
    } arb_state_e;

endpackage

// File: rtl/dmc_ui_arb_tag_fifo.sv
// Tag FIFO recording which requester owns each outstanding read burst, in issue order.
// A push and a pop in the same cycle are both honoured, including when full.
module dmc_ui_arb_tag_fifo #(
    parameter int tag_width_p = 1,
    parameter int depth_p     = 8
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  logic [tag_width_p-1:0] data_i,
    output logic [tag_width_p-1:0] data_o,
    output logic                   full_o,
    output logic                   empty_o
);
    import dmc_ui_arb_pkg::*;

    localparam int ptr_w_lp = $clog2(depth_p);
    localparam int cnt_w_lp = $clog2(depth_p + 1);

    logic [tag_width_p-1:0] mem_q [depth_p];
    logic [tag_width_p-1:0] mem_d [depth_p];
    logic [ptr_w_lp-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [cnt_w_lp-1:0]    count_q, count_d;
    logic                   do_push_s, do_pop_s;

    assign empty_o = (count_q == cnt_w_lp'(0));
    assign full_o  = (count_q == cnt_w_lp'(depth_p));
    assign data_o  = mem_q[rd_ptr_q];

    // Next-state for storage, pointers and occupancy count.
    always_comb begin
        do_pop_s  = pop_i && !empty_o;
        do_push_s = push_i && (!full_o || do_pop_s);
        mem_d     = mem_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        if (do_push_s) begin
            mem_d[wr_ptr_q] = data_i;
            wr_ptr_d        = wr_ptr_q + ptr_w_lp'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (do_pop_s) begin
            rd_ptr_d = rd_ptr_q + ptr_w_lp'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({do_push_s, do_pop_s})
            2'b10:   count_d = count_q + cnt_w_lp'(1);
            2'b01:   count_d = count_q - cnt_w_lp'(1);
            default: count_d = count_q;
        endcase
    end

    // FIFO state registers with synchronous flush.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < depth_p; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            mem_q    <= mem_d;
        end
    end

endmodule

// File: rtl/dmc_ui_arbiter.sv
// Round-robin arbiter sharing one DDR controller app_* port between requesters.
// Write beats stream from the granted lane; read beats are steered back via a tag FIFO.
module dmc_ui_arbiter
    import dmc_ui_arb_pkg::*;
#(
    parameter int num_req_p         = 2,
    parameter int ui_addr_width_p   = 28,
    parameter int ui_data_width_p   = 64,
    parameter int ui_burst_length_p = 8,
    parameter int rd_tag_depth_p    = 8
) (
    input  logic                                     ui_clk_i,
    input  logic                                     ui_reset_i,
    input  logic                                     init_calib_done_i,
    input  logic [num_req_p-1:0]                     req_valid_i,
    input  logic [num_req_p-1:0]                     req_write_i,
    input  logic [num_req_p*ui_addr_width_p-1:0]     req_addr_i,
    output logic [num_req_p-1:0]                     req_ready_o,
    input  logic [num_req_p*ui_data_width_p-1:0]     wdata_i,
    input  logic [num_req_p*ui_data_width_p/8-1:0]   wmask_i,
    input  logic [num_req_p-1:0]                     wdata_valid_i,
    output logic [num_req_p-1:0]                     wdata_ready_o,
    output logic [ui_data_width_p-1:0]               rdata_o,
    output logic [num_req_p-1:0]                     rdata_valid_o,
    output logic                                     rdata_last_o,
    output logic                                     rd_orphan_o,
    output logic [ui_addr_width_p-1:0]               app_addr_o,
    output logic [2:0]                               app_cmd_o,
    output logic                                     app_en_o,
    input  logic                                     app_rdy_i,
    output logic [ui_data_width_p-1:0]               app_wdf_data_o,
    output logic [ui_data_width_p/8-1:0]             app_wdf_mask_o,
    output logic                                     app_wdf_wren_o,
    output logic                                     app_wdf_end_o,
    input  logic                                     app_wdf_rdy_i,
    input  logic [ui_data_width_p-1:0]               app_rd_data_i,
    input  logic                                     app_rd_data_valid_i,
    input  logic                                     app_rd_data_end_i
);
    localparam int tag_w_lp  = $clog2(num_req_p);
    localparam int beat_w_lp = $clog2(ui_burst_length_p);
    localparam int mask_w_lp = ui_data_width_p / 8;

    arb_state_e                 state_q, state_d;
    logic [tag_w_lp-1:0]        grant_q, grant_d, rr_ptr_q, rr_ptr_d;
    logic [ui_addr_width_p-1:0] addr_q, addr_d;
    logic [2:0]                 cmd_q, cmd_d;
    logic [beat_w_lp-1:0]       beat_q, beat_d;
    logic                       orphan_q, orphan_d;
    logic [num_req_p-1:0]       eligible_s;
    logic                       pick_valid_s;
    logic [tag_w_lp-1:0]        pick_idx_s, fifo_head_s;
    logic                       fifo_push_s, fifo_pop_s, fifo_full_s, fifo_empty_s;

    dmc_ui_arb_tag_fifo #(
        .tag_width_p (tag_w_lp),
        .depth_p     (rd_tag_depth_p)
    ) u_tag_fifo (
        .clk_i   (ui_clk_i),
        .reset_i (ui_reset_i),
        .push_i  (fifo_push_s),
        .pop_i   (fifo_pop_s),
        .data_i  (grant_q),
        .data_o  (fifo_head_s),
        .full_o  (fifo_full_s),
        .empty_o (fifo_empty_s)
    );

    assign app_addr_o  = addr_q;
    assign app_cmd_o   = cmd_q;
    assign rd_orphan_o = orphan_q;

    // Round-robin pick: first eligible requester at or after rr_ptr, modulo N.
    always_comb begin
        pick_valid_s = 1'b0;
        pick_idx_s   = '0;
        for (int i = 0; i < num_req_p; i++) begin
            eligible_s[i] = req_valid_i[i] && init_calib_done_i && (req_write_i[i] || !fifo_full_s);
        end
        for (int k = 0; k < num_req_p; k++) begin
            if (!pick_valid_s && eligible_s[(int'(rr_ptr_q) + k) % num_req_p]) begin
                pick_valid_s = 1'b1;
                pick_idx_s   = tag_w_lp'((int'(rr_ptr_q) + k) % num_req_p);
            end else begin
                pick_valid_s = pick_valid_s;
            end
        end
    end

    // Command/write FSM next state plus command handshake and write-lane muxing.
    always_comb begin
        state_d        = state_q;
        grant_d        = grant_q;
        addr_d         = addr_q;
        cmd_d          = cmd_q;
        rr_ptr_d       = rr_ptr_q;
        beat_d         = beat_q;
        app_en_o       = 1'b0;
        req_ready_o    = '0;
        fifo_push_s    = 1'b0;
        wdata_ready_o  = '0;
        app_wdf_wren_o = 1'b0;
        app_wdf_data_o = '0;
        app_wdf_mask_o = '0;
        app_wdf_end_o  = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_valid_s) begin
                    grant_d = pick_idx_s;
                    addr_d  = req_addr_i[int'(pick_idx_s)*ui_addr_width_p +: ui_addr_width_p];
                    cmd_d   = req_write_i[pick_idx_s] ? DMC_CMD_WRITE : DMC_CMD_READ;
                    state_d = CMD;
                end else begin
                    state_d = IDLE;
                end
            end
            CMD: begin
                app_en_o = 1'b1;
                if (app_rdy_i) begin
                    req_ready_o[grant_q] = 1'b1;
                    rr_ptr_d = tag_w_lp'((int'(grant_q) + 1) % num_req_p);
                    if (cmd_q == DMC_CMD_READ) begin
                        fifo_push_s = 1'b1;
                        state_d     = IDLE;
                    end else begin
                        state_d = WDATA;
                    end
                end else begin
                    state_d = CMD;
                end
            end
            WDATA: begin
                app_wdf_wren_o         = wdata_valid_i[grant_q];
                wdata_ready_o[grant_q] = app_wdf_rdy_i;
                app_wdf_data_o = wdata_i[int'(grant_q)*ui_data_width_p +: ui_data_width_p];
                app_wdf_mask_o = wmask_i[int'(grant_q)*mask_w_lp +: mask_w_lp];
                app_wdf_end_o  = (beat_q == beat_w_lp'(ui_burst_length_p - 1));
                if (app_wdf_wren_o && app_wdf_rdy_i) begin
                    if (app_wdf_end_o) begin
                        beat_d  = '0;
                        state_d = IDLE;
                    end else begin
                        beat_d = beat_q + beat_w_lp'(1);
                    end
                end else begin
                    beat_d = beat_q;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Read return steering: route beats to the FIFO head owner, pop on burst end.
    always_comb begin
        rdata_o       = app_rd_data_i;
        rdata_valid_o = '0;
        if (app_rd_data_valid_i && !fifo_empty_s) begin
            rdata_valid_o[fifo_head_s] = 1'b1;
        end else begin
            rdata_valid_o = '0;
        end
        rdata_last_o = app_rd_data_valid_i && app_rd_data_end_i;
        fifo_pop_s   = app_rd_data_valid_i && app_rd_data_end_i && !fifo_empty_s;
        orphan_d     = orphan_q || (app_rd_data_valid_i && fifo_empty_s);
    end

    // Arbiter state registers; reset abandons any burst in flight.
    always_ff @(posedge ui_clk_i) begin
        if (ui_reset_i) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            addr_q   <= '0;
            cmd_q    <= 3'b000;
            rr_ptr_q <= '0;
            beat_q   <= '0;
            orphan_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            addr_q   <= addr_d;
            cmd_q    <= cmd_d;
            rr_ptr_q <= rr_ptr_d;
            beat_q   <= beat_d;
            orphan_q <= orphan_d;
        end
    end

endmodule
